// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared widths, queue depth and RGB555 layout for the video memory arbiter
//
// Purpose: default geometry of the video memory path, RGB555 field positions,
//          the arbitration slot encoding and a colour packing helper.
// Ports:   none (package).
package vga_pkg;

  localparam int ADDR_W_DEF     = 14;
  localparam int DATA_W_DEF     = 15;
  localparam int FIFO_DEPTH_DEF = 4;

  // RGB 5:5:5 field positions inside a block colour word
  localparam int RGB_R_MSB = 14;
  localparam int RGB_R_LSB = 10;
  localparam int RGB_G_MSB = 9;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  // What the single RAM port is used for in a given cycle
  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;

  function automatic logic [14:0] rgb555(input logic [4:0] r,
                                         input logic [4:0] g,
                                         input logic [4:0] b);
    logic [14:0] c;
    c = '0;
    c[RGB_R_MSB:RGB_R_LSB] = r;
    c[RGB_G_MSB:RGB_G_LSB] = g;
    c[RGB_B_MSB:RGB_B_LSB] = b;
    return c;
  endfunction

endpackage

// File: rtl/vid_wr_fifo.sv
// rtl/vid_wr_fifo.sv - synchronous address/data write queue for video memory stores
//
// Purpose: holds processor stores until the arbiter finds a free RAM slot.
// Ports:
//   clk_i        clock
//   rstn_i       synchronous active-low reset, empties the queue
//   push_i       enqueue push_addr_i/push_data_i (ignored when full)
//   pop_i        dequeue the head entry (ignored when empty)
//   head_addr_o  address of the oldest entry
//   head_data_o  colour of the oldest entry
//   full_o       queue holds DEPTH entries
//   empty_o      queue holds no entries
//   level_o      occupancy, 0..DEPTH
module vid_wr_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = ADDR_W_DEF,
  parameter int DW    = DATA_W_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full_o      = (level_q == LW'(DEPTH));
  assign empty_o     = (level_q == '0);
  assign level_o     = level_q;
  assign head_addr_o = addr_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];

  // Push is judged on the registered full flag only, so a same-cycle pop
  // never lets a store in early.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    level_d = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only visible once the level covers it
  always_ff @(posedge clk_i) begin
    if (rstn_i && push_ok) begin
      addr_mem_q[wr_ptr_q] <= push_addr_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/video_mem_arbiter.sv
// rtl/video_mem_arbiter.sv - shares one single-port video RAM between VGA reads and queued stores
//
// Purpose: VGA reads get the RAM whenever the requested block changes; otherwise
//          queued processor stores drain in order. Keeps VGA_DATA coherent with
//          stores that hit the block currently on display.
// Ports:
//   PIXEL_CLK   pixel clock, all state on rising edge
//   RESET_N     synchronous active-low reset
//   VGA_ADDR    block address wanted by the display path
//   VGA_DATA    registered block colour for the display path
//   WR_VALID    processor offers a store
//   WR_READY    store accepted this cycle when high together with WR_VALID
//   WR_ADDR     store address
//   WR_DATA     store colour
//   RAM_ADDR    RAM address (combinational)
//   RAM_WE      RAM write enable (combinational)
//   RAM_WDATA   RAM write data (combinational)
//   RAM_RDATA   RAM read data, one cycle after the read address
//   FIFO_LEVEL  current write-queue occupancy
module video_mem_arbiter
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              PIXEL_CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] VGA_ADDR,
  output logic [DATA_W-1:0] VGA_DATA,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic [LVL_W-1:0]  FIFO_LEVEL
);

  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              last_vld_q, last_vld_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;

  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic              need_read;
  slot_e             slot;

  // Gating with RESET_N keeps the processor side stalled while reset is held
  assign WR_READY  = RESET_N & ~fifo_full;
  assign fifo_push = WR_VALID & WR_READY;

  vid_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_wr_fifo (
    .clk_i       (PIXEL_CLK),
    .rstn_i      (RESET_N),
    .push_i      (fifo_push),
    .push_addr_i (WR_ADDR),
    .push_data_i (WR_DATA),
    .pop_i       (fifo_pop),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (FIFO_LEVEL)
  );

  assign need_read = ~last_vld_q | (VGA_ADDR != last_addr_q);

  // Slot choice and RAM port drive; reads always beat queued writes
  always_comb begin
    slot      = SLOT_IDLE;
    RAM_ADDR  = last_addr_q;
    RAM_WE    = 1'b0;
    RAM_WDATA = '0;
    fifo_pop  = 1'b0;
    if (!RESET_N) begin
      RAM_ADDR = '0;
    end else if (need_read) begin
      slot     = SLOT_READ;
      RAM_ADDR = VGA_ADDR;
    end else if (!fifo_empty) begin
      slot      = SLOT_WRITE;
      RAM_ADDR  = head_addr;
      RAM_WE    = 1'b1;
      RAM_WDATA = head_data;
      fifo_pop  = 1'b1;
    end
  end

  // A write can never share a cycle with a read slot, so last_addr_q here is
  // already the block being displayed (or about to be, when rd_pend_q is set).
  // The write check comes first so fresh store data beats the stale RAM read.
  always_comb begin
    last_addr_d = last_addr_q;
    last_vld_d  = last_vld_q;
    rd_pend_d   = (slot == SLOT_READ);
    vga_data_d  = vga_data_q;
    if (slot == SLOT_READ) begin
      last_addr_d = VGA_ADDR;
      last_vld_d  = 1'b1;
    end
    if (slot == SLOT_WRITE && last_vld_q && head_addr == last_addr_q) begin
      vga_data_d = head_data;
    end else if (rd_pend_q) begin
      vga_data_d = RAM_RDATA;
    end
  end

  always_ff @(posedge PIXEL_CLK) begin
    if (!RESET_N) begin
      last_addr_q <= '0;
      last_vld_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      vga_data_q  <= '0;
    end else begin
      last_addr_q <= last_addr_d;
      last_vld_q  <= last_vld_d;
      rd_pend_q   <= rd_pend_d;
      vga_data_q  <= vga_data_d;
    end
  end

  assign VGA_DATA = vga_data_q;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// tb/tb_video_mem_arbiter.sv - directed self-checking bench for video_mem_arbiter
module tb_video_mem_arbiter;

  logic        PIXEL_CLK = 1'b0;
  logic        RESET_N   = 1'b0;
  logic [13:0] VGA_ADDR  = '0;
  logic [14:0] VGA_DATA;
  logic        WR_VALID  = 1'b0;
  logic        WR_READY;
  logic [13:0] WR_ADDR   = '0;
  logic [14:0] WR_DATA   = '0;
  logic [13:0] RAM_ADDR;
  logic        RAM_WE;
  logic [14:0] RAM_WDATA;
  logic [14:0] RAM_RDATA = '0;
  logic [2:0]  FIFO_LEVEL;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int wr_discard = 0;
  int wr_in_reset = 0;

  logic [14:0] mem [16384];

  video_mem_arbiter dut (
    .PIXEL_CLK  (PIXEL_CLK),
    .RESET_N    (RESET_N),
    .VGA_ADDR   (VGA_ADDR),
    .VGA_DATA   (VGA_DATA),
    .WR_VALID   (WR_VALID),
    .WR_READY   (WR_READY),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_WE     (RAM_WE),
    .RAM_WDATA  (RAM_WDATA),
    .RAM_RDATA  (RAM_RDATA),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  always #20 PIXEL_CLK = ~PIXEL_CLK;

  // Single-port synchronous RAM, read-before-write; preload applied while reset is held
  always @(posedge PIXEL_CLK) begin
    if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
    RAM_RDATA <= mem[RAM_ADDR];
    if (!RESET_N) begin
      mem[14'h0005] <= 15'h7C00;
      mem[14'h0020] <= 15'h1234;
      mem[14'h0202] <= 15'h4321;
    end
  end

  always @(posedge PIXEL_CLK) begin
    if (RAM_WE === 1'b1) begin
      wr_total <= wr_total + 1;
      if (RAM_ADDR >= 14'h0030 && RAM_ADDR <= 14'h0032) wr_discard <= wr_discard + 1;
      if (!RESET_N) wr_in_reset <= wr_in_reset + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, then settle mid-cycle
  task automatic go(input logic rn, input logic [13:0] va, input logic wv,
                    input logic [13:0] wa, input logic [14:0] wd);
    @(posedge PIXEL_CLK);
    #1;
    RESET_N  = rn;
    VGA_ADDR = va;
    WR_VALID = wv;
    WR_ADDR  = wa;
    WR_DATA  = wd;
    #5;
  endtask

  initial begin
    // reset state
    go(1'b0, 14'h5, 1'b0, '0, '0);
    go(1'b0, 14'h5, 1'b0, '0, '0);
    chk("rst_level", 32'(FIFO_LEVEL), 0);
    chk("rst_wr_ready", 32'(WR_READY), 0);
    chk("rst_vga_data", 32'(VGA_DATA), 0);
    chk("rst_ram_we", 32'(RAM_WE), 0);
    chk("rst_ram_addr", 32'(RAM_ADDR), 0);

    // first cycle after reset reads address 5; data visible from cycle 3
    go(1'b1, 14'h5, 1'b0, '0, '0);
    chk("c1_ram_addr", 32'(RAM_ADDR), 32'h5);
    chk("c1_ram_we", 32'(RAM_WE), 0);
    chk("c1_wr_ready", 32'(WR_READY), 1);
    chk("c1_vga_data", 32'(VGA_DATA), 0);
    go(1'b1, 14'h5, 1'b0, '0, '0);
    chk("c2_ram_addr", 32'(RAM_ADDR), 32'h5);
    chk("c2_vga_data", 32'(VGA_DATA), 0);
    go(1'b1, 14'h5, 1'b0, '0, '0);
    chk("c3_vga_data", 32'(VGA_DATA), 32'h7C00);
    go(1'b1, 14'h5, 1'b0, '0, '0);
    chk("c4_vga_data", 32'(VGA_DATA), 32'h7C00);
    chk("c4_ram_we", 32'(RAM_WE), 0);

    // five stores offered while VGA_ADDR changes every cycle
    for (int k = 0; k < 5; k++) begin
      go(1'b1, 14'h100 + 14'(k), 1'b1, 14'h40 + 14'(k), 15'h100 + 15'(k));
      chk("fill_wr_ready", 32'(WR_READY), (k < 4) ? 1 : 0);
      chk("fill_ram_we", 32'(RAM_WE), 0);
      chk("fill_ram_addr", 32'(RAM_ADDR), 32'h100 + k);
    end
    go(1'b1, 14'h105, 1'b0, '0, '0);
    chk("full_level", 32'(FIFO_LEVEL), 4);
    chk("full_ram_we", 32'(RAM_WE), 0);
    for (int k = 0; k < 4; k++) begin
      go(1'b1, 14'h105, 1'b0, '0, '0);
      chk("drain_we", 32'(RAM_WE), 1);
      chk("drain_addr", 32'(RAM_ADDR), 32'h40 + k);
      chk("drain_wdata", 32'(RAM_WDATA), 32'h100 + k);
      chk("drain_level", 32'(FIFO_LEVEL), 4 - k);
    end
    go(1'b1, 14'h105, 1'b0, '0, '0);
    chk("drained_we", 32'(RAM_WE), 0);
    chk("drained_level", 32'(FIFO_LEVEL), 0);
    chk("idle_ram_addr", 32'(RAM_ADDR), 32'h105);

    // ordered drain: 0x10, 0x11, 0x10
    go(1'b1, 14'h105, 1'b1, 14'h10, 15'h1111);
    chk("ord0_we", 32'(RAM_WE), 0);
    chk("ord0_ready", 32'(WR_READY), 1);
    go(1'b1, 14'h105, 1'b1, 14'h11, 15'h2222);
    chk("ord1_we", 32'(RAM_WE), 1);
    chk("ord1_addr", 32'(RAM_ADDR), 32'h10);
    chk("ord1_wdata", 32'(RAM_WDATA), 32'h1111);
    go(1'b1, 14'h105, 1'b1, 14'h10, 15'h3333);
    chk("ord2_we", 32'(RAM_WE), 1);
    chk("ord2_addr", 32'(RAM_ADDR), 32'h11);
    chk("ord2_wdata", 32'(RAM_WDATA), 32'h2222);
    go(1'b1, 14'h105, 1'b0, '0, '0);
    chk("ord3_we", 32'(RAM_WE), 1);
    chk("ord3_addr", 32'(RAM_ADDR), 32'h10);
    chk("ord3_wdata", 32'(RAM_WDATA), 32'h3333);
    go(1'b1, 14'h10, 1'b0, '0, '0);
    chk("rd10_we", 32'(RAM_WE), 0);
    chk("rd10_addr", 32'(RAM_ADDR), 32'h10);
    go(1'b1, 14'h10, 1'b0, '0, '0);
    go(1'b1, 14'h10, 1'b0, '0, '0);
    chk("rd10_vga_data", 32'(VGA_DATA), 32'h3333);

    // write drained right after a read of the same block wins over RAM data
    go(1'b1, 14'h20, 1'b1, 14'h20, 15'h001F);
    chk("rd20_addr", 32'(RAM_ADDR), 32'h20);
    chk("rd20_we", 32'(RAM_WE), 0);
    go(1'b1, 14'h20, 1'b0, '0, '0);
    chk("wr20_we", 32'(RAM_WE), 1);
    chk("wr20_addr", 32'(RAM_ADDR), 32'h20);
    chk("wr20_wdata", 32'(RAM_WDATA), 32'h001F);
    go(1'b1, 14'h20, 1'b0, '0, '0);
    chk("coh_after_read", 32'(VGA_DATA), 32'h001F);

    // later store to the displayed block also updates VGA_DATA
    go(1'b1, 14'h20, 1'b1, 14'h20, 15'h0ABC);
    go(1'b1, 14'h20, 1'b0, '0, '0);
    chk("coh_wr_we", 32'(RAM_WE), 1);
    go(1'b1, 14'h20, 1'b0, '0, '0);
    chk("coh_steady", 32'(VGA_DATA), 32'h0ABC);

    // three stores queued, then reset discards them
    for (int k = 0; k < 3; k++) begin
      go(1'b1, 14'h200 + 14'(k), 1'b1, 14'h30 + 14'(k), 15'h5000 + 15'(k));
    end
    go(1'b1, 14'h203, 1'b0, '0, '0);
    chk("pre_rst_level", 32'(FIFO_LEVEL), 3);
    chk("pre_rst_we", 32'(RAM_WE), 0);
    go(1'b0, 14'h203, 1'b0, '0, '0);
    chk("in_rst_we", 32'(RAM_WE), 0);
    chk("in_rst_ready", 32'(WR_READY), 0);
    chk("in_rst_addr", 32'(RAM_ADDR), 0);
    chk("in_rst_vga_pre", 32'(VGA_DATA), 32'h4321);
    go(1'b0, 14'h203, 1'b0, '0, '0);
    chk("post_rst_level", 32'(FIFO_LEVEL), 0);
    chk("post_rst_vga", 32'(VGA_DATA), 0);
    go(1'b1, 14'h203, 1'b0, '0, '0);
    chk("rel_addr", 32'(RAM_ADDR), 32'h203);
    chk("rel_we", 32'(RAM_WE), 0);
    chk("rel_level", 32'(FIFO_LEVEL), 0);
    for (int k = 0; k < 3; k++) begin
      go(1'b1, 14'h203, 1'b0, '0, '0);
      chk("rel_idle_we", 32'(RAM_WE), 0);
    end

    chk("total_writes", 32'(wr_total), 9);
    chk("discarded_writes", 32'(wr_discard), 0);
    chk("writes_in_reset", 32'(wr_in_reset), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
